video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Generates pixel timing that drives every video source stage: signed sx/sy, hsync, vsync,
//  video_enable, frame_start, line_start. Coordinates are negative during blanking, so
//  (0,0) is the first active pixel. Sits between the pixel-clock domain and the
//  source/compositor. Start/stop happens only on frame boundaries, so downstream stages
//  never see a partial frame.
// PARAMETERS
//  COORDSPC  16    coordinate width (bits, signed)
//  H_RES     1280  active pixels per line
//  H_FP      110   horizontal front porch (pixels)
//  H_SYNC    40    hsync width (pixels)
//  H_BP      220   horizontal back porch (pixels)
//  V_RES     720   active lines per frame
//  V_FP      5     vertical front porch (lines)
//  V_SYNC    5     vsync width (lines)
//  V_BP      20    vertical back porch (lines)
//  H_POL     1     hsync active level (1 = active-high)
//  V_POL     1     vsync active level (1 = active-high)
// PORTS
//  video_clk_pix  in   1         pixel clock
//  video_rst_pix  in   1         synchronous active-high reset
//  run            in   1         1 = generate frames; 0 = stop at the next frame end
//  sx             out  COORDSPC  signed x; H_STA = -(H_FP+H_SYNC+H_BP) .. H_RES-1
//  sy             out  COORDSPC  signed y; V_STA = -(V_FP+V_SYNC+V_BP) .. V_RES-1
//  hsync          out  1         horizontal sync, level per H_POL
//  vsync          out  1         vertical sync, level per V_POL
//  video_enable   out  1         1 iff sx>=0 && sy>=0
//  frame_start    out  1         1-cycle pulse when sx==H_STA && sy==V_STA
//  line_start     out  1         1-cycle pulse when sx==H_STA
//  frame_count    out  32        completed frames (only with VIDEO_TIMING_FRAME_COUNT_EN)
// BEHAVIOUR
//  - All outputs registered. All strobes/syncs are decoded from the same registered sx/sy,
//    so they are mutually consistent in the same cycle.
//  - Reset: state=IDLE, sx=H_STA, sy=V_STA, hsync=!H_POL, vsync=!V_POL,
//    video_enable=0, frame_start=0, line_start=0, frame_count=0.
//  - FSM IDLE:
//      outputs held at their reset values.
//      run=1 at an edge -> ACTIVE. The next cycle shows sx=H_STA, sy=V_STA,
//      frame_start=1, line_start=1 (1-cycle latency from run).
//  - FSM ACTIVE, every cycle:
//      sx++ while sx < H_RES-1.
//      At sx = H_RES-1: sx <- H_STA; sy++, or sy <- V_STA when sy = V_RES-1.
//  - Stop rule: at sx=H_RES-1 && sy=V_RES-1, if run=0 go to IDLE; otherwise wrap into a
//    new frame. run is sampled only on that cycle; a mid-frame deassert is ignored.
//  - hsync active when H_STA+H_FP <= sx < H_STA+H_FP+H_SYNC (default: -260..-221).
//  - vsync active when V_STA+V_FP <= sy < V_STA+V_FP+V_SYNC (default: -25..-21).
//  - vsync is decoded from sy only and changes on the line wrap, aligned to line_start.
//  - Comparisons are signed at COORDSPC width. Elaboration error if H_RES+H_FP+H_SYNC+H_BP
//    or the V total exceeds 2**(COORDSPC-1)-1.
//  - Reset mid-frame: next cycle equals reset values; no partial pulse is emitted.
//  - Simultaneous run=1 and reset: reset wins.
// CONFIGURATION
//  VIDEO_TIMING_FRAME_COUNT_EN defined:
//    adds the frame_count port; it increments (wrapping at 2**32) on the cycle after the
//    last pixel of each completed frame, including a frame that ends in a stop.
//  Undefined: the port and its counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package video_timing_pkg:
//    typedef coord_t (logic signed [COORDSPC-1:0]); enum state_t {ST_IDLE, ST_ACTIVE};
//    functions h_sta()/v_sta() computing the blanking start from the porch parameters.
//  Sub-module video_timing_axis (instantiated twice, for H and V):
//    signed counter with step, wrap-to-start and last flag, plus sync-window decode.
//    The V instance steps on the H instance's last flag.
// TESTING (use small params: H_RES=8,H_FP=2,H_SYNC=2,H_BP=2,V_RES=4,V_FP=1,V_SYNC=1,V_BP=1)
//  1. Reset 3 cycles, run=0 -> sx=-6, sy=-3, syncs inactive, video_enable=0, no pulses.
//  2. run=1 -> next cycle frame_start=1, sx=-6, sy=-3; frame period 14*7=98 cycles;
//     one frame_start per period.
//  3. Sync windows: hsync active sx=-4..-3; vsync active sy=-2 only;
//     video_enable count per frame = 32; line_start count per frame = 7.
//  4. run=0 at sx=0, sy=1 -> frame completes; after sx=7, sy=3 -> IDLE.
//     No further frame_start until run=1.
//  5. Reset at sx=3, sy=2 -> next cycle equals reset values; with run=1 the new frame
//     starts cleanly.
//  6. H_POL=0, V_POL=0 -> syncs idle high and pulse low at the same positions.
//     With VIDEO_TIMING_FRAME_COUNT_EN, frame_count=3 after 3 frames.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the video timing generator.
// Optional feature macro used by the top: VIDEO_TIMING_FRAME_COUNT_EN.
package video_timing_pkg;

   localparam int COORDSPC = 16;

   typedef logic signed [COORDSPC-1:0] coord_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // First horizontal blanking coordinate: the whole blanking interval sits before x=0.
   function automatic int h_sta(input int h_fp, input int h_sync, input int h_bp);
      return -(h_fp + h_sync + h_bp);
   endfunction

   function automatic int v_sta(input int v_fp, input int v_sync, input int v_bp);
      return -(v_fp + v_sync + v_bp);
   endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One timing axis: signed position counter that steps, wraps to the blanking start
// after the last active position, and decodes the sync window from the next position.
module video_timing_axis #(
   parameter int W    = 16,
   parameter int STA  = -370,
   parameter int RES  = 1280,
   parameter int FP   = 110,
   parameter int SYNC = 40
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                step,
   output logic signed [W-1:0] cnt,
   output logic                last,
   output logic                start_nxt,
   output logic                win_nxt,
   output logic                vis_nxt
);

   localparam logic signed [W-1:0] STA_C    = W'(STA);
   localparam logic signed [W-1:0] LAST_C   = W'(RES - 1);
   localparam logic signed [W-1:0] SYNC_LO  = W'(STA + FP);
   localparam logic signed [W-1:0] SYNC_HI  = W'(STA + FP + SYNC);
   localparam logic signed [W-1:0] ONE      = W'(1);

   logic signed [W-1:0] cnt_nxt;

   assign last = (cnt == LAST_C);

   // Next position: hold, increment, or wrap back to the blanking start.
   always_comb begin
      cnt_nxt = cnt;
      if (step) begin
         if (last) begin
            cnt_nxt = STA_C;
         end else begin
            cnt_nxt = cnt + ONE;
         end
      end else begin
         cnt_nxt = cnt;
      end
   end

   // Decodes are taken from the next position so the top can register them alongside cnt.
   assign start_nxt = (cnt_nxt == STA_C);
   assign win_nxt   = (cnt_nxt >= SYNC_LO) && (cnt_nxt < SYNC_HI);
   assign vis_nxt   = ~cnt_nxt[W-1];

   // Position register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= STA_C;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// Pixel timing generator: signed sx/sy, syncs, enable and start strobes, frame-aligned run/stop.
// Define VIDEO_TIMING_FRAME_COUNT_EN to add the 32-bit completed-frame counter port.
module video_timing_gen #(
   parameter int COORDSPC = 16,
   parameter int H_RES    = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_RES    = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter int H_POL    = 1,
   parameter int V_POL    = 1
) (
   input  logic                       video_clk_pix,
   input  logic                       video_rst_pix,
   input  logic                       run,
   output logic signed [COORDSPC-1:0] sx,
   output logic signed [COORDSPC-1:0] sy,
   output logic                       hsync,
   output logic                       vsync,
   output logic                       video_enable,
   output logic                       frame_start,
   output logic                       line_start
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   ,
   output logic [31:0]                frame_count
`endif
);
   import video_timing_pkg::*;

   localparam int   H_STA     = h_sta(H_FP, H_SYNC, H_BP);
   localparam int   V_STA     = v_sta(V_FP, V_SYNC, V_BP);
   localparam int   COORD_MAX = (2 ** (COORDSPC - 1)) - 1;
   localparam logic H_ACT     = (H_POL != 0) ? 1'b1 : 1'b0;
   localparam logic V_ACT     = (V_POL != 0) ? 1'b1 : 1'b0;

   if (H_RES + H_FP + H_SYNC + H_BP > COORD_MAX) begin : g_h_range
      $error("video_timing_gen: horizontal total does not fit in COORDSPC");
   end
   if (V_RES + V_FP + V_SYNC + V_BP > COORD_MAX) begin : g_v_range
      $error("video_timing_gen: vertical total does not fit in COORDSPC");
   end

   state_t state;
   logic   h_step, v_step;
   logic   h_last, v_last;
   logic   h_start_nxt, v_start_nxt;
   logic   h_win_nxt, v_win_nxt;
   logic   h_vis_nxt, v_vis_nxt;
   logic   frame_end;
   logic   active_nxt;

   assign h_step    = (state == ST_ACTIVE);
   assign v_step    = h_step && h_last;
   assign frame_end = h_step && h_last && v_last;
   // run only matters in IDLE and on the last pixel of a frame.
   assign active_nxt = (state == ST_IDLE) ? run : !(frame_end && !run);

   video_timing_axis #(
      .W(COORDSPC), .STA(H_STA), .RES(H_RES), .FP(H_FP), .SYNC(H_SYNC)
   ) u_h_axis (
      .clk(video_clk_pix), .rst(video_rst_pix), .step(h_step),
      .cnt(sx), .last(h_last), .start_nxt(h_start_nxt),
      .win_nxt(h_win_nxt), .vis_nxt(h_vis_nxt)
   );

   video_timing_axis #(
      .W(COORDSPC), .STA(V_STA), .RES(V_RES), .FP(V_FP), .SYNC(V_SYNC)
   ) u_v_axis (
      .clk(video_clk_pix), .rst(video_rst_pix), .step(v_step),
      .cnt(sy), .last(v_last), .start_nxt(v_start_nxt),
      .win_nxt(v_win_nxt), .vis_nxt(v_vis_nxt)
   );

   // Run/stop FSM and registered strobes; a stop forces every output to its idle level.
   always_ff @(posedge video_clk_pix) begin
      if (video_rst_pix) begin
         state        <= ST_IDLE;
         hsync        <= ~H_ACT;
         vsync        <= ~V_ACT;
         video_enable <= 1'b0;
         frame_start  <= 1'b0;
         line_start   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:   state <= run ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: state <= (frame_end && !run) ? ST_IDLE : ST_ACTIVE;
            default:   state <= ST_IDLE;
         endcase
         hsync        <= (active_nxt && h_win_nxt) ? H_ACT : ~H_ACT;
         vsync        <= (active_nxt && v_win_nxt) ? V_ACT : ~V_ACT;
         video_enable <= active_nxt && h_vis_nxt && v_vis_nxt;
         frame_start  <= active_nxt && h_start_nxt && v_start_nxt;
         line_start   <= active_nxt && h_start_nxt;
      end
   end

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   // Counts frames whose last pixel was emitted, including one that ends in a stop.
   always_ff @(posedge video_clk_pix) begin
      if (video_rst_pix) begin
         frame_count <= 32'd0;
      end else if (frame_end) begin
         frame_count <= frame_count + 32'd1;
      end else begin
         frame_count <= frame_count;
      end
   end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: a position-index reference model fills a scoreboard queue each cycle;
// two DUTs (active-high and active-low syncs) are compared against it, plus per-frame totals.
module tb_video_timing_gen;

   localparam int H_RES = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
   localparam int V_RES = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
   localparam int H_TOT = 14, FRAME = 98;
   localparam int H_STA = -6, V_STA = -3;

   typedef struct packed {
      logic signed [15:0] sx;
      logic signed [15:0] sy;
      logic               hs;
      logic               vs;
      logic               ve;
      logic               fs;
      logic               ls;
      logic [31:0]        fc;
   } exp_t;

   exp_t exp_q[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0;
   logic signed [15:0] sx0, sy0, sx1, sy1;
   logic hs0, vs0, ve0, fs0, ls0, hs1, vs1, ve1, fs1, ls1;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
   logic [31:0] fc0, fc1;
`endif

   int checks = 0;
   int errors = 0;
   bit m_active = 1'b0;
   int m_pos = 0;
   int m_fc = 0;

   always #5 clk = ~clk;

   video_timing_gen #(
      .COORDSPC(16), .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .H_POL(1), .V_POL(1)
   ) dut0 (
      .video_clk_pix(clk), .video_rst_pix(rst), .run(run), .sx(sx0), .sy(sy0),
      .hsync(hs0), .vsync(vs0), .video_enable(ve0), .frame_start(fs0), .line_start(ls0)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      , .frame_count(fc0)
`endif
   );

   video_timing_gen #(
      .COORDSPC(16), .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .H_POL(0), .V_POL(0)
   ) dut1 (
      .video_clk_pix(clk), .video_rst_pix(rst), .run(run), .sx(sx1), .sy(sy1),
      .hsync(hs1), .vsync(vs1), .video_enable(ve1), .frame_start(fs1), .line_start(ls1)
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      , .frame_count(fc1)
`endif
   );

   function automatic exp_t obs0();
      exp_t o;
      o = {sx0, sy0, hs0, vs0, ve0, fs0, ls0, 32'd0};
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      o.fc = fc0;
`endif
      return o;
   endfunction

   // Active-low instance seen through inverted syncs so it shares the same expectation.
   function automatic exp_t obs1();
      exp_t o;
      o = {sx1, sy1, ~hs1, ~vs1, ve1, fs1, ls1, 32'd0};
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      o.fc = fc1;
`endif
      return o;
   endfunction

   // Drive one clock of stimulus, advance the model, push the expectation, sample after the edge.
   task automatic cycle(input logic r, input logic rn);
      exp_t e;
      int hx, vy;
      rst = r;
      run = rn;
      if (r) begin
         m_active = 1'b0; m_pos = 0; m_fc = 0;
      end else if (!m_active) begin
         if (rn) begin m_active = 1'b1; m_pos = 0; end
      end else if (m_pos == FRAME - 1) begin
         m_fc++;
         m_pos = 0;
         if (!rn) m_active = 1'b0;
      end else begin
         m_pos++;
      end
      hx = m_active ? (m_pos % H_TOT) + H_STA : H_STA;
      vy = m_active ? (m_pos / H_TOT) + V_STA : V_STA;
      e.sx = 16'(hx);
      e.sy = 16'(vy);
      e.hs = m_active && (hx == -4 || hx == -3);
      e.vs = m_active && (vy == -2);
      e.ve = m_active && hx >= 0 && vy >= 0;
      e.fs = m_active && m_pos == 0;
      e.ls = m_active && (m_pos % H_TOT) == 0;
      e.fc = 32'd0;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      e.fc = 32'(m_fc);
`endif
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         cycle((i < 3) ? 1'b1 : 1'b0, 1'b0);
         e = exp_q.pop_front(); checks++;
         if (obs0() !== e || obs1() !== e) begin
            errors++; $display("FAIL reset_scb cyc %0d: got %h / %h want %h", i, obs0(), obs1(), e);
         end
      end
      checks++;
      if (sx0 !== -16'sd6 || sy0 !== -16'sd3 || hs0 !== 1'b0 || vs0 !== 1'b0 || hs1 !== 1'b1 ||
          vs1 !== 1'b1 || ve0 !== 1'b0 || fs0 !== 1'b0 || ls0 !== 1'b0) begin
         errors++; $display("FAIL reset_vals: got sx=%0d sy=%0d hs=%b vs=%b hs1=%b vs1=%b ve=%b fs=%b ls=%b want -6 -3 0 0 1 1 0 0 0",
                            sx0, sy0, hs0, vs0, hs1, vs1, ve0, fs0, ls0);
      end
   endtask

   task automatic test_frames();
      exp_t e;
      int fs_n, ve_n, ls_n, hs_n, vs_n;
      for (int f = 0; f < 2; f++) begin
         fs_n = 0; ve_n = 0; ls_n = 0; hs_n = 0; vs_n = 0;
         for (int c = 0; c < FRAME; c++) begin
            cycle(1'b0, 1'b1);
            e = exp_q.pop_front(); checks++;
            if (obs0() !== e || obs1() !== e) begin
               errors++; $display("FAIL frame_scb f%0d c%0d: got %h / %h want %h", f, c, obs0(), obs1(), e);
            end
            if (f == 0 && c == 0) begin
               checks++;
               if (fs0 !== 1'b1 || ls0 !== 1'b1 || sx0 !== -16'sd6 || sy0 !== -16'sd3) begin
                  errors++; $display("FAIL run_latency: got fs=%b ls=%b sx=%0d sy=%0d want 1 1 -6 -3", fs0, ls0, sx0, sy0);
               end
            end
            fs_n += int'(fs0); ve_n += int'(ve0); ls_n += int'(ls0);
            hs_n += int'(hs0); vs_n += int'(vs0);
         end
         checks++;
         if (fs_n != 1 || ve_n != 32 || ls_n != 7 || hs_n != 14 || vs_n != 14) begin
            errors++; $display("FAIL frame_totals f%0d: got fs=%0d ve=%0d ls=%0d hs=%0d vs=%0d want 1 32 7 14 14",
                               f, fs_n, ve_n, ls_n, hs_n, vs_n);
         end
      end
   endtask

   task automatic test_stop();
      exp_t e;
      bit found, saw_last;
      int fs_n;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         cycle(1'b0, 1'b1);
         e = exp_q.pop_front(); checks++;
         if (obs0() !== e || obs1() !== e) begin
            errors++; $display("FAIL stop_seek_scb cyc %0d: got %h / %h want %h", i, obs0(), obs1(), e);
         end
         if (sx0 === 16'sd0 && sy0 === 16'sd1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL stop_seek: got no (0,1) within 200 cycles want reached");
      end
      saw_last = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cycle(1'b0, 1'b0);
         e = exp_q.pop_front(); checks++;
         if (obs0() !== e || obs1() !== e) begin
            errors++; $display("FAIL stop_drain_scb cyc %0d: got %h / %h want %h", i, obs0(), obs1(), e);
         end
         if (sx0 === 16'sd7 && sy0 === 16'sd3) saw_last = 1'b1;
      end
      checks++;
      if (!saw_last || sx0 !== -16'sd6 || sy0 !== -16'sd3 || ls0 !== 1'b0) begin
         errors++; $display("FAIL stop_complete: got saw_last=%b sx=%0d sy=%0d ls=%b want 1 -6 -3 0", saw_last, sx0, sy0, ls0);
      end
      fs_n = 0;
      for (int i = 0; i < 120; i++) begin
         cycle(1'b0, 1'b0);
         e = exp_q.pop_front(); checks++;
         if (obs0() !== e || obs1() !== e) begin
            errors++; $display("FAIL idle_scb cyc %0d: got %h / %h want %h", i, obs0(), obs1(), e);
         end
         fs_n += int'(fs0);
      end
      checks++;
      if (fs_n != 0) begin
         errors++; $display("FAIL idle_no_start: got %0d frame_start pulses want 0", fs_n);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit found;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         cycle(1'b0, 1'b1);
         e = exp_q.pop_front(); checks++;
         if (obs0() !== e || obs1() !== e) begin
            errors++; $display("FAIL rmid_seek_scb cyc %0d: got %h / %h want %h", i, obs0(), obs1(), e);
         end
         if (sx0 === 16'sd3 && sy0 === 16'sd2) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL rmid_seek: got no (3,2) within 200 cycles want reached");
      end
      cycle(1'b1, 1'b1);
      e = exp_q.pop_front(); checks++;
      if (obs0() !== e || obs1() !== e) begin
         errors++; $display("FAIL rmid_reset_scb: got %h / %h want %h", obs0(), obs1(), e);
      end
      checks++;
      if (sx0 !== -16'sd6 || sy0 !== -16'sd3 || fs0 !== 1'b0 || ls0 !== 1'b0 || ve0 !== 1'b0 || hs1 !== 1'b1) begin
         errors++; $display("FAIL rmid_reset_vals: got sx=%0d sy=%0d fs=%b ls=%b ve=%b hs1=%b want -6 -3 0 0 0 1",
                            sx0, sy0, fs0, ls0, ve0, hs1);
      end
      for (int c = 0; c < FRAME + 2; c++) begin
         cycle(1'b0, 1'b1);
         e = exp_q.pop_front(); checks++;
         if (obs0() !== e || obs1() !== e) begin
            errors++; $display("FAIL rmid_restart_scb c%0d: got %h / %h want %h", c, obs0(), obs1(), e);
         end
         if (c == 0) begin
            checks++;
            if (fs0 !== 1'b1 || sx0 !== -16'sd6 || sy0 !== -16'sd3) begin
               errors++; $display("FAIL rmid_restart: got fs=%b sx=%0d sy=%0d want 1 -6 -3", fs0, sx0, sy0);
            end
         end
         if (sx0 === -16'sd4) begin
            checks++;
            if (hs1 !== 1'b0 || hs0 !== 1'b1) begin
               errors++; $display("FAIL polarity_hs: got hs0=%b hs1=%b at sx=-4 want 1 0", hs0, hs1);
            end
         end
      end
   endtask

   task automatic test_frame_count();
      exp_t e;
      cycle(1'b1, 1'b0);
      e = exp_q.pop_front(); checks++;
      if (obs0() !== e || obs1() !== e) begin
         errors++; $display("FAIL fc_reset_scb: got %h / %h want %h", obs0(), obs1(), e);
      end
      for (int c = 0; c < 3 * FRAME + 1; c++) begin
         cycle(1'b0, (c < 3 * FRAME) ? 1'b1 : 1'b0);
         e = exp_q.pop_front(); checks++;
         if (obs0() !== e || obs1() !== e) begin
            errors++; $display("FAIL fc_scb c%0d: got %h / %h want %h", c, obs0(), obs1(), e);
         end
      end
      checks++;
      if (sx0 !== -16'sd6 || fs0 !== 1'b0 || vs1 !== 1'b1) begin
         errors++; $display("FAIL fc_stop_idle: got sx=%0d fs=%b vs1=%b want -6 0 1", sx0, fs0, vs1);
      end
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
      checks++;
      if (fc0 !== 32'd3 || fc1 !== 32'd3) begin
         errors++; $display("FAIL frame_count: got %0d / %0d want 3", fc0, fc1);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_frames();
      test_stop();
      test_reset_mid();
      test_frame_count();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
